banked_regfile: RTL and testbench
=================================

# banked_regfile

Banked data register file that consumes the 2-bit bank index produced by the bank-selection counter and performs all general-purpose register reads and writes for the datapath. Four banks share one physical array: the low `NCOMMON` addresses are common registers visible identically from every bank, and the remaining addresses are private per bank. It provides one write port and two registered read ports with same-cycle write-to-read bypass.

## Interface
Parameters:
- `DW`, 8: data width in bits.
- `NREG`, 8: registers visible per bank; power of two, at least 2. `AW = log2(NREG)`.
- `NCOMMON`, 2: low addresses shared across banks; `0 <= NCOMMON < NREG`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `bank_sel`  in  2  current bank index from the bank-selection counter's `q` output; sampled on each rising edge.
- `we`  in  1  write enable.
- `waddr`  in  AW  write address within the bank view.
- `wdata`  in  DW  write data.
- `re_a`  in  1  read enable, port A.
- `raddr_a`  in  AW  read address, port A.
- `re_b`  in  1  read enable, port B.
- `raddr_b`  in  AW  read address, port B.
- `rdata_a`  out  DW  registered read data, port A.
- `rdata_b`  out  DW  registered read data, port B.
- `rvalid_a`  out  1  `rdata_a` updated by a read on the previous edge.
- `rvalid_b`  out  1  `rdata_b` updated by a read on the previous edge.

## Operation
- Physical array: `NCOMMON + 4*(NREG-NCOMMON)` words of `DW` bits.
- Address mapping for address `x` with bank `b = bank_sel`:
  - If `x < NCOMMON`, physical index is `x`.
  - Otherwise, physical index is `NCOMMON + b*(NREG-NCOMMON) + (x-NCOMMON)`.
- Write: at the rising edge with `we=1`, the mapped word is loaded with `wdata`. With `we=0`, the array is unchanged.
- Read, applied independently to ports A and B:
  - At the rising edge with `re_x=1`, `rdata_x` is loaded with the mapped word.
  - If `we=1` and `waddr==raddr_x` at the same edge, `rdata_x` is loaded with `wdata` instead (bypass). Equal addresses under the same `bank_sel` always map to the same physical word.
  - At the rising edge with `re_x=0`, `rdata_x` holds its value.
- `rvalid_x` is loaded with `re_x` at every edge.
- Both ports may read the same address in the same cycle; both return the same value, including the bypass value.
- `bank_sel` is treated as stable across the edge. The same sampled value applies to the write and to both reads in that cycle.
- There are no illegal states. Every `AW`-bit address is valid in every bank.

## Timing
- Reset:
  - While `rst=1`, all array words, `rdata_a`, `rdata_b`, `rvalid_a` and `rvalid_b` are 0, asynchronously and independent of `clk`.
  - Assertion mid-operation clears everything immediately; a write presented on that edge is discarded.
  - After deassertion, the first rising edge operates normally.
- Write latency: a write at edge N is visible to a read issued at edge N (via bypass) and to any later read.
- Read latency: one cycle. A read request at edge N appears on `rdata_x` with `rvalid_x=1` after edge N, and is held until the next edge with `re_x=1`.
- Bank switch: a `bank_sel` change before edge N affects that edge's accesses. Common registers are unaffected by bank changes.

## Test plan
- Reset: apply `rst` mid-cycle after writing `0xA5` to bank 2 address 5 -> outputs are 0 immediately; after release, reading bank 2 address 5 returns `0x00` with `rvalid_a=1`.
- Bank isolation: write `0x11`, `0x22`, `0x33`, `0x44` to address 6 in banks 0-3, then read address 6 in each bank on port B -> returns `0x11`, `0x22`, `0x33`, `0x44` respectively, each one cycle after the request.
- Common window: write `0x5C` to address 1 in bank 3, switch to bank 0 and read address 1 -> returns `0x5C`; write address 2 in bank 0, read it in bank 1 -> returns the bank 1 value (0 after reset).
- Bypass: in one cycle set `we=1`, `waddr=4`, `wdata=0x7E`, `re_a=re_b=1`, `raddr_a=raddr_b=4` -> after that edge both ports show `0x7E`; the next read of address 4 also returns `0x7E`.
- Hold and valid: read address 3 (value `0x09`), then idle 3 cycles with `re_a=0` -> `rdata_a` stays `0x09` and `rvalid_a` is high for exactly one cycle.
- Exhaustive sweep: write a unique pattern `{bank,addr}` to every bank/address pair, then read back all of them on both ports -> every common address returns the value of its last write, and every banked address returns its own pattern.

Source files
------------

// File: rtl/banked_regfile.sv
// ============================================================================
// Module   : banked_regfile
// Brief    : Four-bank register file with a shared common window, one write
//            port and two registered read ports with write-to-read bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module banked_regfile #(
    parameter int DW      = 8,
    parameter int NREG    = 8,
    parameter int NCOMMON = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              bank_sel,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [DW-1:0]           wdata,
    input  logic                    re_a,
    input  logic [$clog2(NREG)-1:0] raddr_a,
    input  logic                    re_b,
    input  logic [$clog2(NREG)-1:0] raddr_b,
    output logic [DW-1:0]           rdata_a,
    output logic [DW-1:0]           rdata_b,
    output logic                    rvalid_a,
    output logic                    rvalid_b
);

    localparam int c_AW    = $clog2(NREG);
    localparam int c_NPRIV = NREG - NCOMMON;
    localparam int c_DEPTH = NCOMMON + 4 * c_NPRIV;
    localparam int c_PW    = $clog2(c_DEPTH);

    logic [DW-1:0]   r_mem [c_DEPTH];
    logic [DW-1:0]   r_rdata_a;
    logic [DW-1:0]   r_rdata_b;
    logic            r_rvalid_a;
    logic            r_rvalid_b;
    logic [c_PW-1:0] w_widx;
    logic [c_PW-1:0] w_ridx_a;
    logic [c_PW-1:0] w_ridx_b;
    logic            w_byp_a;
    logic            w_byp_b;

    // Common addresses bypass the bank offset; private ones are stacked per bank.
    function automatic logic [c_PW-1:0] map_addr(input logic [c_AW-1:0] x,
                                                 input logic [1:0]      b);
        int idx;
        if (int'(x) < NCOMMON)
            idx = int'(x);
        else
            idx = NCOMMON + int'(b) * c_NPRIV + (int'(x) - NCOMMON);
        return idx[c_PW-1:0];
    endfunction

    always_comb begin
        w_widx   = map_addr(waddr, bank_sel);
        w_ridx_a = map_addr(raddr_a, bank_sel);
        w_ridx_b = map_addr(raddr_b, bank_sel);
        w_byp_a  = we && (waddr == raddr_a);
        w_byp_b  = we && (waddr == raddr_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[w_widx] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
        end else begin
            r_rvalid_a <= re_a;
            r_rvalid_b <= re_b;
            if (re_a)
                r_rdata_a <= w_byp_a ? wdata : r_mem[w_ridx_a];
            if (re_b)
                r_rdata_b <= w_byp_b ? wdata : r_mem[w_ridx_b];
        end
    end

    assign rdata_a  = r_rdata_a;
    assign rdata_b  = r_rdata_b;
    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;

endmodule

`default_nettype wire

// File: tb/tb_banked_regfile.sv
// ============================================================================
// Module   : tb_banked_regfile
// Brief    : Directed self-checking bench for banked_regfile.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_banked_regfile;

    logic       clk;
    logic       rst;
    logic [1:0] bank_sel;
    logic       we;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic       re_a;
    logic [2:0] raddr_a;
    logic       re_b;
    logic [2:0] raddr_b;
    logic [7:0] rdata_a;
    logic [7:0] rdata_b;
    logic       rvalid_a;
    logic       rvalid_b;

    int total = 0;
    int bad   = 0;

    banked_regfile #(.DW(8), .NREG(8), .NCOMMON(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bank_sel (bank_sel),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .re_a     (re_a),
        .raddr_a  (raddr_a),
        .re_b     (re_b),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .rvalid_a (rvalid_a),
        .rvalid_b (rvalid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus drivers: inputs change 1 time unit after the rising edge.
    task automatic do_write(input logic [1:0] b, input logic [2:0] a, input logic [7:0] d);
        bank_sel = b; we = 1'b1; waddr = a; wdata = d;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] b, input logic ea, input logic [2:0] aa,
                           input logic eb, input logic [2:0] ab);
        bank_sel = b; re_a = ea; raddr_a = aa; re_b = eb; raddr_b = ab;
        @(posedge clk); #1;
        re_a = 1'b0; re_b = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (rdata_a !== 8'h00 || rvalid_a !== 1'b0 || rdata_b !== 8'h00 || rvalid_b !== 1'b0) begin
            bad++;
            $display("FAIL reset_init got a=%h va=%b b=%h vb=%b want 00 0 00 0", rdata_a, rvalid_a, rdata_b, rvalid_b);
        end
        do_write(2'd2, 3'd5, 8'hA5);
        do_read(2'd2, 1'b1, 3'd5, 1'b0, 3'd0);
        total++;
        if (rdata_a !== 8'hA5 || rvalid_a !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre got %h v=%b want a5 1", rdata_a, rvalid_a);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (rdata_a !== 8'h00 || rvalid_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_async got %h v=%b want 00 0", rdata_a, rvalid_a);
        end
        @(posedge clk); #3 rst = 1'b0;
        @(posedge clk); #1;
        do_read(2'd2, 1'b1, 3'd5, 1'b0, 3'd0);
        total++;
        if (rdata_a !== 8'h00 || rvalid_a !== 1'b1) begin
            bad++;
            $display("FAIL reset_cleared got %h v=%b want 00 1", rdata_a, rvalid_a);
        end
    endtask

    task automatic test_common();
        do_write(2'd3, 3'd1, 8'h5C);
        do_read(2'd0, 1'b1, 3'd1, 1'b0, 3'd0);
        total++;
        if (rdata_a !== 8'h5C) begin
            bad++;
            $display("FAIL common_shared got %h want 5c", rdata_a);
        end
        do_write(2'd0, 3'd2, 8'h3D);
        do_read(2'd1, 1'b1, 3'd2, 1'b0, 3'd0);
        total++;
        if (rdata_a !== 8'h00) begin
            bad++;
            $display("FAIL common_private got %h want 00", rdata_a);
        end
        do_read(2'd0, 1'b0, 3'd0, 1'b1, 3'd2);
        total++;
        if (rdata_b !== 8'h3D) begin
            bad++;
            $display("FAIL common_own_bank got %h want 3d", rdata_b);
        end
    endtask

    task automatic test_bank_isolation();
        logic [7:0] exp_v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int b = 0; b < 4; b++) do_write(2'(b), 3'd6, exp_v[b]);
        for (int b = 0; b < 4; b++) begin
            do_read(2'(b), 1'b0, 3'd0, 1'b1, 3'd6);
            total++;
            if (rdata_b !== exp_v[b] || rvalid_b !== 1'b1) begin
                bad++;
                $display("FAIL isolation bank%0d got %h v=%b want %h 1", b, rdata_b, rvalid_b, exp_v[b]);
            end
        end
    endtask

    task automatic test_bypass();
        bank_sel = 2'd1; we = 1'b1; waddr = 3'd4; wdata = 8'h7E;
        re_a = 1'b1; raddr_a = 3'd4; re_b = 1'b1; raddr_b = 3'd4;
        @(posedge clk); #1;
        we = 1'b0; re_a = 1'b0; re_b = 1'b0;
        total++;
        if (rdata_a !== 8'h7E || rdata_b !== 8'h7E || rvalid_a !== 1'b1 || rvalid_b !== 1'b1) begin
            bad++;
            $display("FAIL bypass got a=%h b=%h va=%b vb=%b want 7e 7e 1 1", rdata_a, rdata_b, rvalid_a, rvalid_b);
        end
        do_read(2'd1, 1'b1, 3'd4, 1'b0, 3'd0);
        total++;
        if (rdata_a !== 8'h7E) begin
            bad++;
            $display("FAIL bypass_stored got %h want 7e", rdata_a);
        end
    endtask

    task automatic test_hold_valid();
        do_write(2'd0, 3'd3, 8'h09);
        do_read(2'd0, 1'b1, 3'd3, 1'b0, 3'd0);
        total++;
        if (rdata_a !== 8'h09 || rvalid_a !== 1'b1) begin
            bad++;
            $display("FAIL hold_read got %h v=%b want 09 1", rdata_a, rvalid_a);
        end
        // Write a different value to the same word during idle: held data must not follow it.
        do_write(2'd0, 3'd3, 8'hF0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
        end
        total++;
        if (rdata_a !== 8'h09 || rvalid_a !== 1'b0) begin
            bad++;
            $display("FAIL hold_idle got %h v=%b want 09 0", rdata_a, rvalid_a);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 8; a++)
                do_write(2'(b), 3'(a), 8'(b * 8 + a));
        for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < 8; a++) begin
                do_read(2'(b), 1'b1, 3'(a), 1'b1, 3'(7 - a));
                exp_a = (a < 2) ? 8'(24 + a) : 8'(b * 8 + a);
                exp_b = ((7 - a) < 2) ? 8'(24 + 7 - a) : 8'(b * 8 + 7 - a);
                total++;
                if (rdata_a !== exp_a || rdata_b !== exp_b || rvalid_a !== 1'b1 || rvalid_b !== 1'b1) begin
                    bad++;
                    $display("FAIL sweep b%0d a%0d got a=%h b=%h want a=%h b=%h", b, a, rdata_a, rdata_b, exp_a, exp_b);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; bank_sel = 2'd0; we = 1'b0; waddr = 3'd0; wdata = 8'h00;
        re_a = 1'b0; raddr_a = 3'd0; re_b = 1'b0; raddr_b = 3'd0;
        #12 rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_common();
        test_bank_isolation();
        test_bypass();
        test_hold_valid();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
